sar_search_ctrl: RTL and testbench
==================================

Name: sar_search_ctrl

Overview:
- Successive-approximation search controller. It drives a trial value into an external magnitude comparator (comparator A = trial, B = hidden target) and consumes the comparator's less/equal/greater result.
- It binary-searches the target bit by bit, MSB first, and reports the recovered value.
- The block sits on the initiator side of the magnitude-comparator interface and is paired with the 4-bit comparator in the comparator subsystem.

Parameters:
- WIDTH, 4, width of trial/result and number of SAR bit steps.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a search; sampled only in IDLE.
- less  in  1  comparator flag: trial < target.
- equal  in  1  comparator flag: trial == target.
- greater  in  1  comparator flag: trial > target.
- trial  out  WIDTH  value driven to comparator A.
- busy  out  1  high in PROBE and VERIFY.
- done  out  1  one-cycle pulse when the search completes.
- found  out  1  last compare reported equal; valid from done until the next start.
- result  out  WIDTH  recovered value; valid from done until the next start.
- Interface (already decided): one clock; reset is synchronous and active-high; ports are named clk and rst.

Behaviour:
- Reset values: trial=0, busy=0, done=0, found=0, result=0, state=IDLE, bit index=WIDTH-1. rst asserted mid-search aborts the search; all outputs take their reset values at that edge and no done is issued.
- States: IDLE, PROBE, VERIFY, DONE.
- IDLE: on start, trial <= 1<<(WIDTH-1), idx <= WIDTH-1, found <= 0, go to PROBE.
- PROBE: flags are sampled at the end of the cycle (the comparator is combinational on trial).
  - equal: result <= trial, found <= 1, go to DONE (early exit).
  - greater: clear trial[idx].
  - less: keep trial[idx].
  - If not exiting and idx>0: set trial[idx-1], idx <= idx-1, stay in PROBE.
  - If idx==0: go to VERIFY with the adjusted trial.
- VERIFY: one probe of the final trial. found <= equal, result <= trial, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. result and found hold.
- Flag priority without the feature below: equal > greater > less. If no flag is set, treat it as less.
- Latency: probes ≤ WIDTH+1. done arrives (number of probes + 1) cycles after the start cycle. Minimum is 2 cycles (early equal on the first probe). Maximum is WIDTH+2 cycles (target 0 needs a VERIFY).
- start while busy or in DONE: ignored; no queuing.
- trial holds stable throughout each probe cycle and holds its last value in DONE/IDLE.
- All arithmetic is unsigned WIDTH-bit. No wrap-around is possible because bits are only set or cleared.

Optional Feature:
- Macro SAR_FLAG_CHECK_EN.
- When defined: in PROBE/VERIFY, a flag vector that is not exactly one-hot aborts the search at that edge. Outputs: found=0, result=trial at that cycle, and an extra output flag_err=1 pulsed alongside done; next state is DONE.
- When undefined: the flag_err port does not exist, and the priority rule above applies.

Decomposition:
- Package sar_pkg contains:
  - state enum (IDLE, PROBE, VERIFY, DONE);
  - default width constant SAR_WIDTH_DEF=4;
  - flag vector index constants (LT=0, EQ=1, GT=2).
- Single flat module; no sub-module needed. The bench instantiates the existing 4-bit comparator as the partner, with its B tied to the target.

Test Plan:
- Target 5, WIDTH=4, start pulse: trials 1000, 0100, 0110, 0101 on consecutive cycles, then done=1, found=1, result=0101, 5 cycles after start.
- Target 15: trials 1000, 1100, 1110, 1111 (equal); done with found=1, result=1111; no VERIFY.
- Target 0: trials 1000, 0100, 0010, 0001, 0000 (VERIFY equal); done at cycle 6, found=1, result=0000.
- Comparator with greater stuck high (comparator stubbed): search ends at VERIFY 0000, found=0, result=0000. With SAR_FLAG_CHECK_EN and less+greater forced together: flag_err=1 and done on the first probe.
- rst asserted on the second PROBE cycle of target 9: the next cycle shows trial=0, busy=0, and no done. A fresh start then completes with result=1001.
- start re-pulsed while busy (target 6): ignored; exactly one done with result=0110, and busy stays continuous.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROBE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } sar_state_e;

    localparam int SAR_WIDTH_DEF = 4;

    // Bit positions inside the {greater, equal, less} flag vector
    localparam int LT = 0;
    localparam int EQ = 1;
    localparam int GT = 2;

    function automatic logic flags_onehot(input logic [2:0] flags);
        return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// SAR search controller: binary-searches a hidden target MSB first through an external comparator.
// Optional macro SAR_FLAG_CHECK_EN adds the flag_err output and aborts on non-one-hot flags.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result
`ifdef SAR_FLAG_CHECK_EN
    ,
    output logic             flag_err
`endif
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_e        state_r, state_next_s;
    logic [IDX_W-1:0]  idx_r, idx_next_s;
    logic [WIDTH-1:0]  trial_r, trial_next_s, adj_s;
    logic [WIDTH-1:0]  result_r, result_next_s;
    logic              found_r, found_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic              err_r, err_next_s;
    logic [2:0]        flags_s;
    logic              flags_bad_s;

    assign flags_s = {greater, equal, less};

`ifdef SAR_FLAG_CHECK_EN
    assign flags_bad_s = !flags_onehot(flags_s);
`else
    assign flags_bad_s = 1'b0;
`endif

    // Next-state and next-output computation
    always_comb begin
        state_next_s  = state_r;
        idx_next_s    = idx_r;
        trial_next_s  = trial_r;
        result_next_s = result_r;
        found_next_s  = found_r;
        err_next_s    = 1'b0;
        adj_s         = trial_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    trial_next_s          = '0;
                    trial_next_s[WIDTH-1] = 1'b1;
                    idx_next_s            = IDX_W'(WIDTH - 1);
                    found_next_s          = 1'b0;
                    state_next_s          = PROBE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PROBE: begin
                if (flags_bad_s) begin
                    found_next_s  = 1'b0;
                    result_next_s = trial_r;
                    err_next_s    = 1'b1;
                    state_next_s  = DONE;
                end else begin
                    // Priority: equal exits, then greater clears, otherwise (less or nothing) keep
                    casez (flags_s)
                        3'b?1?: begin
                            result_next_s = trial_r;
                            found_next_s  = 1'b1;
                            state_next_s  = DONE;
                        end
                        3'b1?0,
                        3'b1?1: adj_s[idx_r] = 1'b0;
                        default: adj_s[idx_r] = trial_r[idx_r];
                    endcase
                    if (!flags_s[EQ]) begin
                        if (idx_r != '0) begin
                            adj_s[idx_r - 1'b1] = 1'b1;
                            idx_next_s          = idx_r - 1'b1;
                        end else begin
                            state_next_s = VERIFY;
                        end
                        trial_next_s = adj_s;
                    end else begin
                        trial_next_s = trial_r;
                    end
                end
            end
            VERIFY: begin
                if (flags_bad_s) begin
                    found_next_s = 1'b0;
                    err_next_s   = 1'b1;
                end else begin
                    found_next_s = flags_s[EQ];
                end
                result_next_s = trial_r;
                state_next_s  = DONE;
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        busy_next_s = (state_next_s == PROBE) || (state_next_s == VERIFY);
        done_next_s = (state_next_s == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            idx_r    <= IDX_W'(WIDTH - 1);
            trial_r  <= '0;
            result_r <= '0;
            found_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            idx_r    <= idx_next_s;
            trial_r  <= trial_next_s;
            result_r <= result_next_s;
            found_r  <= found_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
            err_r    <= err_next_s;
        end
    end

    assign trial  = trial_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign found  = found_r;
    assign result = result_r;

`ifdef SAR_FLAG_CHECK_EN
    assign flag_err = err_r;
`else
    logic unused_err_s;
    assign unused_err_s = err_r;
`endif

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench: comparator partner modelled inline, expected trials derived from integer search arithmetic.
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         less, equal, greater;
    logic [W-1:0] trial, result;
    logic         busy, done, found;
`ifdef SAR_FLAG_CHECK_EN
    logic         flag_err;
`endif

    logic [W-1:0] target = '0;
    int           fmode = 0;
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_q[$];
    logic         exp_found, exp_err;
    logic [W-1:0] exp_result;

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .less(less), .equal(equal), .greater(greater),
        .trial(trial), .busy(busy), .done(done), .found(found), .result(result)
`ifdef SAR_FLAG_CHECK_EN
        , .flag_err(flag_err)
`endif
    );

    always #5 clk = ~clk;

    // Comparator environment: mode 0 real, 1 greater stuck, 2 less+greater, 3 less stuck plus real eq/gt
    function automatic logic [2:0] env_flags(input logic [W-1:0] p, input logic [W-1:0] t, input int mode);
        case (mode)
            1:       return 3'b100;
            2:       return 3'b101;
            3:       return {p > t, p == t, 1'b1};
            default: return {p > t, p == t, p < t};
        endcase
    endfunction

    logic [2:0] fl;
    always_comb fl = env_flags(trial, target, fmode);
    assign less    = fl[0];
    assign equal   = fl[1];
    assign greater = fl[2];

    // 0 = lt, 1 = eq, 2 = gt, 3 = invalid flag vector
    function automatic int classify(input logic [2:0] f);
`ifdef SAR_FLAG_CHECK_EN
        if (f != 3'b001 && f != 3'b010 && f != 3'b100) return 3;
`endif
        if (f[1]) return 1;
        if (f[2]) return 2;
        return 0;
    endfunction

    task automatic model(input logic [W-1:0] tgt, input int mode);
        logic [W-1:0] acc, p;
        int c;
        acc = '0;
        exp_q.delete();
        exp_found = 1'b0;
        exp_err = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            p = acc | (4'd1 << i);
            exp_q.push_back(p);
            c = classify(env_flags(p, tgt, mode));
            if (c == 3) begin exp_result = p; exp_err = 1'b1; return; end
            if (c == 1) begin exp_result = p; exp_found = 1'b1; return; end
            if (c == 0) acc = p;
        end
        exp_q.push_back(acc);
        c = classify(env_flags(acc, tgt, mode));
        exp_result = acc;
        if (c == 3) exp_err = 1'b1;
        else exp_found = (c == 1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge following the done cycle
    task automatic run_search(input logic [W-1:0] tgt, input int mode, input bit repulse, input string tag);
        int cycles, k;
        target = tgt;
        fmode = mode;
        model(tgt, mode);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        k = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (k < exp_q.size()) chk({tag, "_trial"}, trial, exp_q[k]);
            chk({tag, "_busy"}, busy, 1'b1);
            k++;
            start = repulse && (k == 2);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_latency"}, cycles, exp_q.size() + 1);
        chk({tag, "_result"}, result, exp_result);
        chk({tag, "_found"}, found, exp_found);
        chk({tag, "_busy_done"}, busy, 1'b0);
`ifdef SAR_FLAG_CHECK_EN
        chk({tag, "_flag_err"}, flag_err, exp_err);
`endif
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_result_hold"}, result, exp_result);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int seen_done;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_trial", trial, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_found", found, 1'b0);
        chk("rst_result", result, 4'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_search(4'd5, 0, 1'b0, "t5");
        chk("t5_lat_const", exp_q.size() + 1, 5);
        run_search(4'd15, 0, 1'b0, "t15");
        run_search(4'd0, 0, 1'b0, "t0");
        chk("t0_lat_const", exp_q.size() + 1, 6);
        run_search(4'd3, 1, 1'b0, "stuck_gt");
        run_search(4'd7, 2, 1'b0, "lt_gt");
        run_search(4'd10, 3, 1'b0, "stuck_lt");

        // Reset on the second probe cycle aborts without done
        target = 4'd9;
        fmode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst9_probe1", trial, 4'b1000);
        @(posedge clk); #1;
        chk("rst9_probe2", trial, 4'b1100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst9_trial", trial, 4'd0);
        chk("rst9_busy", busy, 1'b0);
        chk("rst9_done", done, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        chk("rst9_no_done", seen_done, 0);
        run_search(4'd9, 0, 1'b0, "t9");
        chk("t9_result_const", result, 4'b1001);

        run_search(4'd6, 0, 1'b1, "repulse6");
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        chk("repulse6_no_second", seen_done, 0);

        for (int n = 0; n < 12; n++) begin
            run_search(4'($urandom_range(0, 15)), 0, 1'b0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
